// File: rtl/tl_pkg.sv
// Shared definitions for the intersection phase scheduler.
//   phase_t : phase codes MG=0, MY=1, AR1=2, CG=3, CY=4, AR2=5
//   lamp_t  : 3-bit lamp code, GRN=001, YEL=010, RED=100
//   TW      : phase timer width
//   main_lamp / cross_lamp : lamp code shown on each road in a phase
package tl_pkg;

    localparam int unsigned TW = 5;

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5
    } phase_t;

    typedef logic [2:0] lamp_t;

    localparam lamp_t GRN = 3'b001;
    localparam lamp_t YEL = 3'b010;
    localparam lamp_t RED = 3'b100;

    function automatic lamp_t main_lamp(input phase_t p);
        case (p)
            MG:      return GRN;
            MY:      return YEL;
            default: return RED;
        endcase
    endfunction

    function automatic lamp_t cross_lamp(input phase_t p);
        case (p)
            CG:      return GRN;
            CY:      return YEL;
            default: return RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for phase timing.
//   clk_1Hz  in  tick clock
//   reset    in  asynchronous, active-high; count returns to RST_VAL
//   load     in  load load_val on the next edge (has priority)
//   load_val in  value to load
//   count    out current value; decrements each edge, saturates at 0
//   zero     out count == 0
module phase_timer #(
    parameter int unsigned    W       = 5,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_1Hz,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset)
            count <= RST_VAL;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/actuated_phase_scheduler.sv
// Demand-driven two-road intersection sequencer on the 1 Hz tick.
//   clk_1Hz    in  tick clock
//   reset      in  asynchronous, active-high
//   cross_req  in  cross-road vehicle sensor (level)
//   ped_req    in  pedestrian button (level)
//   emerg_main in  emergency preemption favouring the main road (level)
//   main_st    out main lamps (001 green, 010 yellow, 100 red)
//   cross_st   out cross lamps, same code
//   walk       out cross pedestrian walk lamp
//   phase      out current phase code
//   time_left  out phase timer, 0 on the expiry cycle
//   preempt    out registered copy of emerg_main
module actuated_phase_scheduler
    import tl_pkg::*;
#(
    parameter int unsigned MAIN_MIN = 15,
    parameter int unsigned YEL_T    = 3,
    parameter int unsigned AR_T     = 1,
    parameter int unsigned CROSS_T  = 10,
    parameter int unsigned WALK_T   = 7
) (
    input  logic          clk_1Hz,
    input  logic          reset,
    input  logic          cross_req,
    input  logic          ped_req,
    input  logic          emerg_main,
    output logic [2:0]    main_st,
    output logic [2:0]    cross_st,
    output logic          walk,
    output logic [2:0]    phase,
    output logic [TW-1:0] time_left,
    output logic          preempt
);

    phase_t        state, next_state;
    logic          req_pend, ped_pend;
    logic          tmr_load, tmr_zero;
    logic [TW-1:0] tmr_load_val;
    logic [TW-1:0] walk_left, nxt_walk_left;
    logic          nxt_walk, cg_entry;
    lamp_t         nxt_main, nxt_cross;

    function automatic logic [TW-1:0] dur_m1(input phase_t p);
        case (p)
            MG:      return TW'(MAIN_MIN - 1);
            MY, CY:  return TW'(YEL_T - 1);
            CG:      return TW'(CROSS_T - 1);
            default: return TW'(AR_T - 1);
        endcase
    endfunction

    // Any phase change reloads the timer with the new phase's duration - 1.
    assign tmr_load     = (next_state != state);
    assign tmr_load_val = dur_m1(next_state);

    phase_timer #(
        .W       (TW),
        .RST_VAL (TW'(MAIN_MIN - 1))
    ) u_timer (
        .clk_1Hz  (clk_1Hz),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .count    (time_left),
        .zero     (tmr_zero)
    );

    // State and output registers
    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            state     <= MG;
            main_st   <= GRN;
            cross_st  <= RED;
            walk      <= 1'b0;
            walk_left <= '0;
            preempt   <= 1'b0;
        end else begin
            state     <= next_state;
            main_st   <= nxt_main;
            cross_st  <= nxt_cross;
            walk      <= nxt_walk;
            walk_left <= nxt_walk_left;
            preempt   <= emerg_main;
        end
    end

    // Request latches; clearing on CG entry beats a same-edge request.
    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            req_pend <= 1'b0;
            ped_pend <= 1'b0;
        end else if (cg_entry) begin
            req_pend <= 1'b0;
            ped_pend <= 1'b0;
        end else begin
            req_pend <= req_pend | cross_req;
            ped_pend <= ped_pend | ped_req;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            MG:  if (tmr_zero && (req_pend || ped_pend) && !emerg_main) next_state = MY;
            MY:  if (tmr_zero) next_state = AR1;
            AR1: if (tmr_zero) next_state = CG;
            CG:  if (tmr_zero || emerg_main) next_state = CY;
            CY:  if (tmr_zero) next_state = AR2;
            AR2: if (tmr_zero) next_state = MG;
            default: next_state = AR2;
        endcase
    end

    // Next-output logic; lamps/walk are registered alongside the phase
    always_comb begin
        cg_entry      = (next_state == CG) && (state != CG);
        nxt_main      = main_lamp(next_state);
        nxt_cross     = cross_lamp(next_state);
        nxt_walk      = 1'b0;
        nxt_walk_left = walk_left;
        if (cg_entry) begin
            nxt_walk      = ped_pend;
            nxt_walk_left = TW'(WALK_T - 1);
        end else if (next_state == CG && walk_left != '0) begin
            // walk_left counts the remaining walk clocks after the current one
            nxt_walk      = walk;
            nxt_walk_left = walk_left - TW'(1);
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_actuated_phase_scheduler.sv
module tb_actuated_phase_scheduler;

    localparam int MAIN_MIN = 15;
    localparam int YEL_T    = 3;
    localparam int AR_T     = 1;
    localparam int CROSS_T  = 10;
    localparam int WALK_T   = 7;

    logic       clk_1Hz = 1'b0;
    logic       reset;
    logic       cross_req, ped_req, emerg_main;
    logic [2:0] main_st, cross_st, phase;
    logic [4:0] time_left;
    logic       walk, preempt;

    int vectors = 0;
    int miscompares = 0;

    actuated_phase_scheduler #(
        .MAIN_MIN (MAIN_MIN),
        .YEL_T    (YEL_T),
        .AR_T     (AR_T),
        .CROSS_T  (CROSS_T),
        .WALK_T   (WALK_T)
    ) dut (
        .clk_1Hz    (clk_1Hz),
        .reset      (reset),
        .cross_req  (cross_req),
        .ped_req    (ped_req),
        .emerg_main (emerg_main),
        .main_st    (main_st),
        .cross_st   (cross_st),
        .walk       (walk),
        .phase      (phase),
        .time_left  (time_left),
        .preempt    (preempt)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    // ---------------- behavioural model ----------------
    // Phases are indices 0..5 of a fixed ring; each has a duration and lamps.
    int dur[6]       = '{MAIN_MIN, YEL_T, AR_T, CROSS_T, YEL_T, AR_T};
    int main_tab[6]  = '{1, 2, 4, 4, 4, 4};
    int cross_tab[6] = '{4, 4, 4, 1, 2, 4};

    int m_ph, m_tl, m_age, np;
    bit m_req, m_ped, m_walk_on, m_pre, adv;

    always @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            m_ph = 0; m_tl = MAIN_MIN - 1; m_age = 0;
            m_req = 0; m_ped = 0; m_walk_on = 0; m_pre = 0;
        end else begin
            if (m_ph == 0)      adv = (m_tl == 0) && (m_req || m_ped) && !emerg_main;
            else if (m_ph == 3) adv = (m_tl == 0) || emerg_main;
            else                adv = (m_tl == 0);
            np = adv ? (m_ph + 1) % 6 : m_ph;
            if (adv && np == 3) begin
                m_walk_on = m_ped;
                m_age = 0;
                m_req = 0;
                m_ped = 0;
            end else begin
                if (np == 3) m_age++;
                m_req |= cross_req;
                m_ped |= ped_req;
            end
            m_tl  = adv ? dur[np] - 1 : (m_tl > 0 ? m_tl - 1 : 0);
            m_ph  = np;
            m_pre = emerg_main;
        end
    end

    function automatic bit exp_walk();
        return (m_ph == 3) && m_walk_on && (m_age < WALK_T);
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk_1Hz) begin
        if (!reset) begin
            vectors++;
            if (phase !== 3'(m_ph) || time_left !== 5'(m_tl) ||
                main_st !== 3'(main_tab[m_ph]) || cross_st !== 3'(cross_tab[m_ph]) ||
                walk !== exp_walk() || preempt !== m_pre) begin
                miscompares++;
                $display("FAIL model t=%0t: got ph=%0d tl=%0d m=%b c=%b w=%b p=%b, want ph=%0d tl=%0d m=%b c=%b w=%b p=%b",
                         $time, phase, time_left, main_st, cross_st, walk, preempt,
                         m_ph, m_tl, 3'(main_tab[m_ph]), 3'(cross_tab[m_ph]), exp_walk(), m_pre);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_phase"}, phase, 0);
        chk({tag, "_tl"}, time_left, 14);
        chk({tag, "_main"}, main_st, 1);
        chk({tag, "_cross"}, cross_st, 4);
        chk({tag, "_walk"}, walk, 0);
        chk({tag, "_preempt"}, preempt, 0);
    endtask

    // ---------------- stimulus ----------------
    int  emerg_cnt;
    int  n;
    bit  found;

    initial begin
        reset = 1'b1; cross_req = 0; ped_req = 0; emerg_main = 0;
        #18;
        chk_reset_state("rst");
        #4 reset = 1'b0;   // released at t=22, first edge at t=25 is clk 1

        // Directed timeline; k = number of edges since reset release.
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk_1Hz);
            case (k)
                14:  begin chk("c14_phase", phase, 0); chk("c14_tl", time_left, 0); end
                15:  begin chk("c15_phase", phase, 1); chk("c15_tl", time_left, 2); end
                18:  chk("c18_phase", phase, 2);
                19:  begin chk("c19_phase", phase, 3); chk("c19_tl", time_left, 9); chk("c19_walk", walk, 0); end
                29:  chk("c29_phase", phase, 4);
                32:  chk("c32_phase", phase, 5);
                33:  begin chk("c33_phase", phase, 0); chk("c33_tl", time_left, 14); end
                52:  begin chk("c52_phase", phase, 3); chk("c52_walk", walk, 1); end
                58:  chk("c58_walk", walk, 1);
                59:  begin chk("c59_phase", phase, 3); chk("c59_walk", walk, 0); end
                62:  chk("c62_phase", phase, 4);
                86:  begin chk("c86_phase", phase, 3); chk("c86_walk", walk, 1); end
                87:  begin chk("c87_phase", phase, 4); chk("c87_walk", walk, 0); chk("c87_preempt", preempt, 1); end
                111: chk("c111_phase", phase, 0);
                112: chk("c112_phase", phase, 1);
                116: chk("c116_phase", phase, 3);
                144: chk("c144_phase", phase, 0);
                145: chk("c145_phase", phase, 1);
                default: ;
            endcase
            n = k + 1;   // edge at which the inputs below are sampled
            cross_req  = (n == 3) || (n == 70) || (n == 95) || (n >= 114 && n <= 118);
            ped_req    = (n == 40) || (n == 70);
            emerg_main = (n >= 87 && n <= 111);
        end

        // Randomised traffic
        emerg_cnt = 0;
        for (int k = 0; k < 1300; k++) begin
            @(negedge clk_1Hz);
            cross_req = ($urandom_range(0, 19) == 0);
            ped_req   = ($urandom_range(0, 29) == 0);
            if (emerg_cnt > 0) begin
                emerg_cnt--;
                emerg_main = 1'b1;
            end else begin
                emerg_main = 1'b0;
                if ($urandom_range(0, 99) == 0) emerg_cnt = $urandom_range(1, 40);
            end
        end

        // Drive into CY, then reset mid-phase without a clock edge
        emerg_main = 0; cross_req = 1; ped_req = 0;
        found = 0;
        for (int k = 0; k < 150 && !found; k++) begin
            @(negedge clk_1Hz);
            if (m_ph == 4) found = 1;
        end
        chk("reach_cy", found, 1);
        cross_req = 0;
        #2 reset = 1'b1;
        #1 chk_reset_state("midrst");
        @(negedge clk_1Hz);
        #2 reset = 1'b0;
        for (int k = 0; k < 20; k++) @(negedge clk_1Hz);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
